grid_pattern_gen: RTL and testbench
===================================

// Module: grid_pattern_gen
// PURPOSE
//  Parametrised COLS x ROWS bitmap animator that drives the VGA display data bus.
//  A single-clock tick divider paces the animation; no derived clocks are generated.
//  Four run-time modes: FILL, DRAIN, WALK and CHECKER. Supports pause and single-step.
//  Bitmap is flat: pixel (r,c) = data[r*COLS+c]; N = COLS*ROWS.
// PARAMETERS
//  COLS      16       grid columns
//  ROWS      12       grid rows
//  STEP_DIV  2500000  clocks per animation tick, >=1 (20 Hz at 50 MHz)
// PORTS
//  clock       in   1      system clock
//  reset       in   1      asynchronous, active-low
//  run         in   1      1: free-running ticks; 0: divider held
//  step        in   1      with run=0, a 1-cycle pulse forces one tick next cycle
//  mode        in   2      0 FILL, 1 DRAIN, 2 WALK, 3 CHECKER
//  data        out  N      bitmap to the display
//  index       out  IDXW   current sweep position, IDXW = $clog2(N+1)
//  tick        out  1      1-cycle pulse on the cycle the bitmap updates
//  sweep_done  out  1      1-cycle pulse when a sweep period ends
// BEHAVIOUR
//  Reset: data=0, index=0, tick=0, sweep_done=0, div counter=0, mode_q=FILL.
//  Divider: cnt counts 0..STEP_DIV-1 while run=1; tick_int is asserted when cnt==STEP_DIV-1, then cnt wraps to 0.
//   STEP_DIV=1: tick every cycle. run=0: cnt held; step=1 gives tick_int next cycle.
//   A step pulse while run=1 is ignored.
//  Outputs are registered. data, index, tick and sweep_done all change on the same edge.
//  Mode change: if mode!=mode_q, the next edge sets mode_q=mode, index=0, cnt=0 and data=init(mode).
//   Asserts no tick and no sweep_done. Has priority over a coincident tick.
//  init(): FILL 0; DRAIN all ones; WALK bit0 only; CHECKER pattern A.
//   Pattern A: bit(r,c) = (r+c)&1.
//  Per tick:
//   FILL:    idx<N  -> data[idx]<=1, idx++
//            idx==N -> data<=0, idx<=0, sweep_done
//            Period is N+1 ticks.
//   DRAIN:   idx<N  -> data[idx]<=0, idx++
//            idx==N -> data<=all ones, idx<=0, sweep_done
//   WALK:    data = 1<<idx.
//            idx==N-1 -> idx<=0, sweep_done; else idx++.
//   CHECKER: data <= ~data. idx toggles 0/1.
//            sweep_done when data returns to pattern A.
//  index never exceeds N. All index arithmetic uses IDXW bits with no overflow.
//  Asynchronous reset mid-sweep returns all state to the reset values immediately.
// CONFIGURATION
//  GRID_BOUNCE_EN defined:
//   WALK ping-pongs 0..N-1..0 using an internal dir bit (reset dir=up).
//   Direction reverses at idx==N-1 and at idx==0.
//   sweep_done pulses on arrival back at 0.
//   Period is 2N-2 ticks (N=1: constant bit0).
//  GRID_BOUNCE_EN undefined:
//   WALK wraps N-1 -> 0 and the dir bit does not exist.
// STRUCTURE
//  Package grid_pkg:
//   mode localparams MODE_FILL/DRAIN/WALK/CHECKER.
//   function checker_init(COLS,ROWS) returning pattern A.
//  Sub-module grid_tick_div:
//   parameter STEP_DIV; inputs run, step; output tick_int; clr input for mode restart.
//  Top level: mode_q register, index/data update FSM keyed on mode_q, output registers.
// TESTING  (COLS=4, ROWS=3, N=12, STEP_DIV=4)
//  1. Reset released, mode=0, run=1:
//     data=12'h000 until first tick; 12 ticks -> 12'hFFF; 13th tick -> 12'h000 with sweep_done=1 for one cycle.
//  2. run=1: ticks exactly 4 clocks apart.
//     run=0: no ticks for 20 clocks; one step pulse -> exactly one tick next cycle; index advances by 1.
//  3. mode=2: data 001,002,...,800 then 001 with sweep_done.
//     With GRID_BOUNCE_EN: 800 -> 400 ... -> 001, sweep_done on 001.
//  4. mode=3: init 12'hA5A, then 5A5, then A5A with sweep_done every 2nd tick.
//  5. FILL at index=5, switch mode to 1 on a cycle where cnt==3:
//     next edge data=12'hFFF, index=0, tick=0; next tick clears bit0.
//  6. reset asserted mid-WALK, asynchronous to clock:
//     data=0, index=0 and tick=0 with no clock edge; restarts in FILL after release.

Source files
------------

// File: rtl/grid_pkg.sv
// ============================================================================
//  grid_pkg
//  Shared mode encodings and the checkerboard seed pattern for grid_pattern_gen.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package grid_pkg;

  localparam logic [1:0] MODE_FILL    = 2'd0;
  localparam logic [1:0] MODE_DRAIN   = 2'd1;
  localparam logic [1:0] MODE_WALK    = 2'd2;
  localparam logic [1:0] MODE_CHECKER = 2'd3;

  typedef enum logic [1:0] {
    M_FILL    = MODE_FILL,
    M_DRAIN   = MODE_DRAIN,
    M_WALK    = MODE_WALK,
    M_CHECKER = MODE_CHECKER
  } grid_mode_e;

  // Upper bound on the bitmap size the seed function can describe.
  localparam int GRID_MAX_N = 1024;

  function automatic logic [GRID_MAX_N-1:0] checker_init(input int cols, input int rows);
    logic [GRID_MAX_N-1:0] pat;
    pat = '0;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        pat[10'(r * cols + c)] = (((r + c) % 2) == 1);
      end
    end
    return pat;
  endfunction

endpackage

`default_nettype wire

// File: rtl/grid_tick_div.sv
// ============================================================================
//  grid_tick_div
//  Animation tick divider with run/hold, single-step and synchronous restart.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module grid_tick_div #(
  parameter int STEP_DIV = 2500000
) (
  input  logic clock,
  input  logic reset,
  input  logic i_run,
  input  logic i_step,
  input  logic i_clr,
  output logic o_tick_int
);

  localparam int             CW     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0]  c_last = CW'(STEP_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_step_pend;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_step_pend <= 1'b0;
    end else if (i_clr) begin
      r_cnt       <= '0;
      r_step_pend <= 1'b0;
    end else begin
      // A step only counts while the divider is held.
      r_step_pend <= !i_run && i_step;
      if (i_run) begin
        r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + CW'(1);
      end
    end
  end

  assign o_tick_int = (i_run && (r_cnt == c_last)) || r_step_pend;

endmodule

`default_nettype wire

// File: rtl/grid_pattern_gen.sv
// ============================================================================
//  grid_pattern_gen
//  COLS x ROWS bitmap animator (FILL/DRAIN/WALK/CHECKER) for the display bus.
//  Build option: GRID_BOUNCE_EN makes WALK ping-pong instead of wrapping.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module grid_pattern_gen
  import grid_pkg::*;
#(
  parameter int COLS     = 16,
  parameter int ROWS     = 12,
  parameter int STEP_DIV = 2500000
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               i_run,
  input  logic                               i_step,
  input  logic [1:0]                         i_mode,
  output logic [COLS*ROWS-1:0]               o_data,
  output logic [$clog2(COLS*ROWS+1)-1:0]     o_index,
  output logic                               o_tick,
  output logic                               o_sweep_done
);

  localparam int N    = COLS * ROWS;
  localparam int IDXW = $clog2(N + 1);

  localparam logic [GRID_MAX_N-1:0] c_pat_full = checker_init(COLS, ROWS);
  localparam logic [N-1:0]          c_pat_a    = c_pat_full[N-1:0];
  localparam logic [N-1:0]          c_one      = N'(1);
  localparam logic [IDXW-1:0]       c_n_idx    = IDXW'(N);
  localparam logic [IDXW-1:0]       c_last     = IDXW'(N - 1);
  localparam logic [IDXW-1:0]       c_idx_one  = IDXW'(1);

  grid_mode_e        r_mode;
  logic [N-1:0]      r_data;
  logic [IDXW-1:0]   r_index;
  logic              r_tick;
  logic              r_sweep_done;
`ifdef GRID_BOUNCE_EN
  logic              r_dir;
  logic              w_next_dir;
`endif

  logic              w_tick_int;
  logic              w_mode_chg;
  logic [N-1:0]      w_init;
  logic [N-1:0]      w_next_data;
  logic [IDXW-1:0]   w_next_idx;
  logic              w_sweep;

  assign w_mode_chg = (i_mode != r_mode);

  grid_tick_div #(
    .STEP_DIV (STEP_DIV)
  ) u_tick_div (
    .clock      (clock),
    .reset      (reset),
    .i_run      (i_run),
    .i_step     (i_step),
    .i_clr      (w_mode_chg),
    .o_tick_int (w_tick_int)
  );

  always_comb begin
    w_init = '0;
    case (i_mode)
      MODE_FILL:    w_init = '0;
      MODE_DRAIN:   w_init = '1;
      MODE_WALK:    w_init = c_one;
      default:      w_init = c_pat_a;
    endcase
  end

  always_comb begin
    w_next_data = r_data;
    w_next_idx  = r_index;
    w_sweep     = 1'b0;
`ifdef GRID_BOUNCE_EN
    w_next_dir  = r_dir;
`endif
    case (r_mode)
      M_FILL: begin
        if (r_index < c_n_idx) begin
          w_next_data = r_data | (c_one << r_index);
          w_next_idx  = r_index + c_idx_one;
        end else begin
          w_next_data = '0;
          w_next_idx  = '0;
          w_sweep     = 1'b1;
        end
      end
      M_DRAIN: begin
        if (r_index < c_n_idx) begin
          w_next_data = r_data & ~(c_one << r_index);
          w_next_idx  = r_index + c_idx_one;
        end else begin
          w_next_data = '1;
          w_next_idx  = '0;
          w_sweep     = 1'b1;
        end
      end
      M_WALK: begin
`ifdef GRID_BOUNCE_EN
        if (r_dir) begin
          if (r_index == c_last) begin
            w_next_idx = (c_last == '0) ? '0 : r_index - c_idx_one;
            w_next_dir = 1'b0;
          end else begin
            w_next_idx = r_index + c_idx_one;
          end
        end else begin
          w_next_idx = r_index - c_idx_one;
        end
        // Arriving at the bottom ends the period and turns the walk back up.
        if (w_next_idx == '0) begin
          w_sweep    = 1'b1;
          w_next_dir = 1'b1;
        end
`else
        if (r_index == c_last) begin
          w_next_idx = '0;
          w_sweep    = 1'b1;
        end else begin
          w_next_idx = r_index + c_idx_one;
        end
`endif
        w_next_data = c_one << w_next_idx;
      end
      default: begin
        w_next_data = ~r_data;
        w_next_idx  = (r_index == '0) ? c_idx_one : '0;
        w_sweep     = (~r_data == c_pat_a);
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mode       <= M_FILL;
      r_data       <= '0;
      r_index      <= '0;
      r_tick       <= 1'b0;
      r_sweep_done <= 1'b0;
`ifdef GRID_BOUNCE_EN
      r_dir        <= 1'b1;
`endif
    end else if (w_mode_chg) begin
      // Restart wins over any tick landing on the same edge.
      r_mode       <= grid_mode_e'(i_mode);
      r_data       <= w_init;
      r_index      <= '0;
      r_tick       <= 1'b0;
      r_sweep_done <= 1'b0;
`ifdef GRID_BOUNCE_EN
      r_dir        <= 1'b1;
`endif
    end else if (w_tick_int) begin
      r_data       <= w_next_data;
      r_index      <= w_next_idx;
      r_tick       <= 1'b1;
      r_sweep_done <= w_sweep;
`ifdef GRID_BOUNCE_EN
      r_dir        <= w_next_dir;
`endif
    end else begin
      r_tick       <= 1'b0;
      r_sweep_done <= 1'b0;
    end
  end

  assign o_data       = r_data;
  assign o_index      = r_index;
  assign o_tick       = r_tick;
  assign o_sweep_done = r_sweep_done;

endmodule

`default_nettype wire

// File: tb/tb_grid_pattern_gen.sv
// ============================================================================
//  tb_grid_pattern_gen
//  Directed and randomized checks of grid_pattern_gen against a phase model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_grid_pattern_gen;

  localparam int COLS     = 4;
  localparam int ROWS     = 3;
  localparam int N        = COLS * ROWS;
  localparam int STEP_DIV = 4;
  localparam int IDXW     = $clog2(N + 1);

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            run   = 1'b0;
  logic            step  = 1'b0;
  logic [1:0]      mode  = 2'd0;
  logic [N-1:0]    data;
  logic [IDXW-1:0] index;
  logic            tick;
  logic            sweep_done;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // Model state: the animation is a position within a per-mode period.
  int           m_mode;
  int           m_phase;
  int           m_cnt;
  bit           m_pend;
  bit           e_tick;
  bit           e_sd;
  logic [N-1:0] pat_a;

  always #5 clock = ~clock;

  grid_pattern_gen #(
    .COLS     (COLS),
    .ROWS     (ROWS),
    .STEP_DIV (STEP_DIV)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .i_run        (run),
    .i_step       (step),
    .i_mode       (mode),
    .o_data       (data),
    .o_index      (index),
    .o_tick       (tick),
    .o_sweep_done (sweep_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int period(input int md);
    case (md)
      0, 1:    return N + 1;
`ifdef GRID_BOUNCE_EN
      2:       return (N > 1) ? 2 * N - 2 : 1;
`else
      2:       return N;
`endif
      default: return 2;
    endcase
  endfunction

  function automatic int exp_pos();
`ifdef GRID_BOUNCE_EN
    if (m_mode == 2 && m_phase > N - 1) return 2 * N - 2 - m_phase;
`endif
    return m_phase;
  endfunction

  function automatic logic [N-1:0] exp_data();
    logic [N-1:0] one;
    logic [N-1:0] low;
    int           p;
    one = 1;
    p   = exp_pos();
    low = (one << p) - one;
    case (m_mode)
      0:       return low;
      1:       return ~low;
      2:       return one << p;
      default: return (m_phase != 0) ? ~pat_a : pat_a;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_cnt = 0; m_pend = 0; e_tick = 0; e_sd = 0;
  endtask

  task automatic model_step();
    bit fire;
    if (int'(mode) != m_mode) begin
      m_mode = int'(mode); m_phase = 0; m_cnt = 0; m_pend = 0; e_tick = 0; e_sd = 0;
    end else begin
      fire   = (run && m_cnt == STEP_DIV - 1) || m_pend;
      m_pend = !run && step;
      if (run) m_cnt = (m_cnt == STEP_DIV - 1) ? 0 : m_cnt + 1;
      e_tick = fire;
      e_sd   = 0;
      if (fire) begin
        m_phase = (m_phase + 1) % period(m_mode);
        e_sd    = (m_phase == 0);
      end
    end
  endtask

  task automatic check_outputs();
    chk("data",       32'(data),       32'(exp_data()));
    chk("index",      32'(index),      32'(exp_pos()));
    chk("tick",       32'(tick),       32'(e_tick));
    chk("sweep_done", 32'(sweep_done), 32'(e_sd));
  endtask

  task automatic cycle();
    @(posedge clock);
    if (!reset) model_reset();
    else        model_step();
    @(negedge clock);
    check_outputs();
  endtask

  task automatic wait_tick(input int bound, output int waited);
    waited = 0;
    do begin
      cycle();
      waited++;
    end while (!tick && waited < bound);
    if (!tick) chk("tick_timeout", 32'(tick), 32'd1);
  endtask

  initial begin
    int w;
    int nt;
    int idx0;
    int idx1;
    bit found;

    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        pat_a[r * COLS + c] = ((r + c) % 2 == 1);
    chk("pattern_a_seed", 32'(pat_a), 32'hA5A);

    model_reset();
    repeat (3) @(negedge clock);
    check_outputs();
    chk("reset_data", 32'(data), 32'h0);

    // FILL sweep from reset
    reset = 1'b1; mode = 2'd0; run = 1'b1;
    for (int t = 1; t <= 13; t++) begin
      wait_tick(20, w);
      if (t == 1)  chk("t1_first", 32'(data), 32'h001);
      if (t == 12) chk("t1_full", 32'(data), 32'hFFF);
      if (t == 13) begin
        chk("t1_clear", 32'(data), 32'h000);
        chk("t1_sweep", 32'(sweep_done), 32'd1);
      end
    end
    cycle();
    chk("t1_sweep_pulse", 32'(sweep_done), 32'd0);

    // Tick spacing, hold and single step
    wait_tick(20, w);
    wait_tick(20, w);
    chk("t2_spacing_a", 32'(w), 32'd4);
    wait_tick(20, w);
    chk("t2_spacing_b", 32'(w), 32'd4);
    run = 1'b0;
    nt  = 0;
    repeat (20) begin
      cycle();
      nt += int'(tick);
    end
    chk("t2_hold_ticks", 32'(nt), 32'd0);
    idx0 = int'(index);
    idx1 = -1;
    step = 1'b1;
    cycle();
    step = 1'b0;
    nt   = 0;
    repeat (5) begin
      cycle();
      if (tick) begin
        nt++;
        idx1 = int'(index);
      end
    end
    chk("t2_step_ticks", 32'(nt), 32'd1);
    chk("t2_step_index", 32'(idx1), 32'(idx0 + 1));

    // WALK
    mode = 2'd2; run = 1'b1;
    cycle();
    chk("t3_init", 32'(data), 32'h001);
    for (int t = 1; t <= 12; t++) begin
      wait_tick(20, w);
      if (t == 1)  chk("t3_second", 32'(data), 32'h002);
      if (t == 11) chk("t3_top", 32'(data), 32'h800);
`ifdef GRID_BOUNCE_EN
      if (t == 12) begin
        chk("t3_bounce", 32'(data), 32'h400);
        chk("t3_bounce_sd", 32'(sweep_done), 32'd0);
      end
`else
      if (t == 12) begin
        chk("t3_wrap", 32'(data), 32'h001);
        chk("t3_wrap_sd", 32'(sweep_done), 32'd1);
      end
`endif
    end
`ifdef GRID_BOUNCE_EN
    for (int t = 13; t <= 22; t++) wait_tick(20, w);
    chk("t3_return", 32'(data), 32'h001);
    chk("t3_return_sd", 32'(sweep_done), 32'd1);
`endif

    // CHECKER
    mode = 2'd3;
    cycle();
    chk("t4_init", 32'(data), 32'hA5A);
    wait_tick(20, w);
    chk("t4_inv", 32'(data), 32'h5A5);
    chk("t4_inv_sd", 32'(sweep_done), 32'd0);
    wait_tick(20, w);
    chk("t4_back", 32'(data), 32'hA5A);
    chk("t4_back_sd", 32'(sweep_done), 32'd1);

    // Mode switch coinciding with a tick
    mode  = 2'd0;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      cycle();
      found = (m_mode == 0 && m_phase == 5 && m_cnt == STEP_DIV - 1);
    end
    chk("t5_index", 32'(index), 32'd5);
    mode = 2'd1;
    cycle();
    chk("t5_data", 32'(data), 32'hFFF);
    chk("t5_idx0", 32'(index), 32'd0);
    chk("t5_notick", 32'(tick), 32'd0);
    wait_tick(20, w);
    chk("t5_drain0", 32'(data), 32'hFFE);

    // Randomized run/step/mode traffic
    for (int i = 0; i < 600; i++) begin
      run  = ($urandom_range(0, 3) != 0);
      step = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 99) == 0) mode = 2'($urandom_range(0, 3));
      cycle();
    end
    step = 1'b0;

    // Asynchronous reset mid-WALK
    mode = 2'd2; run = 1'b1;
    repeat (10) cycle();
    #2 reset = 1'b0;
    #1;
    chk("t6_data", 32'(data), 32'h0);
    chk("t6_index", 32'(index), 32'd0);
    chk("t6_tick", 32'(tick), 32'd0);
    mode = 2'd0;
    cycle();
    reset = 1'b1;
    wait_tick(20, w);
    chk("t6_fill_data", 32'(data), 32'h001);
    chk("t6_fill_index", 32'(index), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
